// File: rtl/dm_arb_pkg_8085.sv
// Shared types for the 8085 data-memory arbiter: arbitration state and owner encoding.
package dm_arb_pkg_8085;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOCK_CPU = 2'd1,
    ST_LOCK_DBG = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/dm_arb_pick_8085.sv
// Combinational grant picker: single requester always wins; on contention an
// unexpired lock wins, otherwise the requester that did not own last time.
module dm_arb_pick_8085
  import dm_arb_pkg_8085::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HW       = 3
) (
  input  logic          cpu_req_i,
  input  logic          dbg_req_i,
  input  arb_state_e    state_i,
  input  logic [HW-1:0] hold_cnt_i,
  input  owner_e        last_owner_i,
  output logic          cpu_pick_o,
  output logic          dbg_pick_o
);

  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

  logic hold_ok;
  assign hold_ok = (hold_cnt_i < MAX_HOLD_C);

  always_comb begin
    cpu_pick_o = 1'b0;
    dbg_pick_o = 1'b0;
    if (cpu_req_i && dbg_req_i) begin
      if (state_i == ST_LOCK_CPU && hold_ok) begin
        cpu_pick_o = 1'b1;
      end else if (state_i == ST_LOCK_DBG && hold_ok) begin
        dbg_pick_o = 1'b1;
      end else if (last_owner_i == OWN_DBG) begin
        cpu_pick_o = 1'b1;
      end else begin
        dbg_pick_o = 1'b1;
      end
    end else if (cpu_req_i) begin
      cpu_pick_o = 1'b1;
    end else if (dbg_req_i) begin
      dbg_pick_o = 1'b1;
    end
  end

endmodule

// File: rtl/dm_arbiter_8085.sv
// Two-port arbiter in front of the 8085 single-port data memory: zero-latency
// grant, registered per-requester read-valid, read data passed straight through.
module dm_arbiter_8085
  import dm_arb_pkg_8085::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_lock,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_lock,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          cpu_gnt,
  output logic          dbg_gnt,
  output logic          cpu_rvalid,
  output logic          dbg_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    arb_state
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

  // Handshake: X_req is held until X_gnt; an access is issued in the cycle
  // X_req & X_gnt are both high, and a read answers with X_rvalid one edge later.
  arb_state_e    state_q, state_d;
  owner_e        last_owner_q, last_owner_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          cpu_rvalid_q, dbg_rvalid_q;
  logic          cpu_pick, dbg_pick;
  logic          contend;
  owner_e        gnt_owner;

  dm_arb_pick_8085 #(.MAX_HOLD(MAX_HOLD), .HW(HW)) u_pick (
    .cpu_req_i    (cpu_req),
    .dbg_req_i    (dbg_req),
    .state_i      (state_q),
    .hold_cnt_i   (hold_cnt_q),
    .last_owner_i (last_owner_q),
    .cpu_pick_o   (cpu_pick),
    .dbg_pick_o   (dbg_pick)
  );

  // No access may reach the memory while reset is asserted.
  assign cpu_gnt   = cpu_pick & ~reset;
  assign dbg_gnt   = dbg_pick & ~reset;
  assign mem_en    = cpu_gnt | dbg_gnt;
  assign mem_we    = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);
  assign mem_addr  = dbg_gnt ? dbg_addr : cpu_addr;
  assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
  assign rdata     = mem_rdata;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign arb_state  = state_q;
  assign contend    = cpu_req & dbg_req;
  assign gnt_owner  = dbg_gnt ? OWN_DBG : OWN_CPU;

  // hold_cnt counts consecutive contended grants to the current owner, the
  // first one included, so a lock yields after MAX_HOLD grants under contention.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    if ((state_q == ST_LOCK_CPU && !cpu_req) || (state_q == ST_LOCK_DBG && !dbg_req)) begin
      state_d = ST_IDLE;
    end
    if (cpu_gnt || dbg_gnt) begin
      last_owner_d = gnt_owner;
      if (cpu_gnt) begin
        state_d = cpu_lock ? ST_LOCK_CPU : ST_IDLE;
      end else begin
        state_d = dbg_lock ? ST_LOCK_DBG : ST_IDLE;
      end
      if (!contend) begin
        hold_cnt_d = '0;
      end else if (gnt_owner != last_owner_q) begin
        hold_cnt_d = HW'(1);
      end else if (hold_cnt_q < MAX_HOLD_C) begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end else begin
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_DBG;
      hold_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      dbg_rvalid_q <= dbg_gnt & ~dbg_we;
    end
  end

endmodule

// File: tb/tb_dm_arbiter_8085.sv
// Directed bench for dm_arbiter_8085 with a behavioural DM and a queue scoreboard.
module tb_dm_arbiter_8085;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_lock;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       dbg_req, dbg_we, dbg_lock;
  logic [7:0] dbg_addr, dbg_wdata;
  logic       cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
  logic [7:0] rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0] arb_state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0] gnt;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } gnt_exp_t;

  typedef struct packed {
    logic [1:0] rv;
    logic [7:0] data;
  } rd_exp_t;

  gnt_exp_t exp_gnt_q[$];
  rd_exp_t  exp_rd_q[$];
  gnt_exp_t mon_g;
  rd_exp_t  mon_r;

  logic [7:0] dm [256];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dm_arbiter_8085 #(.AW(8), .DW(8), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_lock   (cpu_lock),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_lock   (dbg_lock),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .cpu_gnt    (cpu_gnt),
    .dbg_gnt    (dbg_gnt),
    .cpu_rvalid (cpu_rvalid),
    .dbg_rvalid (dbg_rvalid),
    .rdata      (rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .arb_state  (arb_state)
  );

  // Synchronous single-port DM: read data appears the edge after the read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dm[mem_addr] <= mem_wdata;
      else        mem_rdata    <= dm[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic cr, cw, cl, input logic [7:0] ca, cd,
                       input logic dr, dw, dl, input logic [7:0] da, dd,
                       input logic [1:0] eg, input logic [7:0] erd);
    gnt_exp_t g;
    rd_exp_t  r;
    cpu_req = cr; cpu_we = cw; cpu_lock = cl; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_lock = dl; dbg_addr = da; dbg_wdata = dd;
    if (eg == 2'b10) begin
      g = '{gnt: eg, we: cw, addr: ca, wdata: cd};
      exp_gnt_q.push_back(g);
      if (!cw) begin
        r = '{rv: 2'b10, data: erd};
        exp_rd_q.push_back(r);
      end
    end else if (eg == 2'b01) begin
      g = '{gnt: eg, we: dw, addr: da, wdata: dd};
      exp_gnt_q.push_back(g);
      if (!dw) begin
        r = '{rv: 2'b01, data: erd};
        exp_rd_q.push_back(r);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic cpu_only(input logic we, lock, input logic [7:0] addr, wdata, erd);
    drive(1'b1, we, lock, addr, wdata, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b10, erd);
  endtask

  task automatic dbg_only(input logic we, input logic [7:0] addr, wdata, erd);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, we, 1'b0, addr, wdata, 2'b01, erd);
  endtask

  task automatic both_rd(input logic cl, input logic [7:0] ca, da, input logic [1:0] eg,
                         input logic [7:0] erd);
    drive(1'b1, 1'b0, cl, ca, 8'h00, 1'b1, 1'b0, 1'b0, da, 8'h00, eg, erd);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (cpu_gnt || dbg_gnt) begin
      if (exp_gnt_q.size() == 0) begin
        check("unexpected_gnt", {30'd0, cpu_gnt, dbg_gnt}, 32'd0);
      end else begin
        mon_g = exp_gnt_q.pop_front();
        check("gnt", {30'd0, cpu_gnt, dbg_gnt}, {30'd0, mon_g.gnt});
        check("mem_en", {31'd0, mem_en}, 32'd1);
        check("mem_we", {31'd0, mem_we}, {31'd0, mon_g.we});
        check("mem_addr", {24'd0, mem_addr}, {24'd0, mon_g.addr});
        if (mon_g.we) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, mon_g.wdata});
      end
    end
    if (cpu_rvalid || dbg_rvalid) begin
      if (exp_rd_q.size() == 0) begin
        check("unexpected_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'd0);
      end else begin
        mon_r = exp_rd_q.pop_front();
        check("rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, {30'd0, mon_r.rv});
        check("rdata", {24'd0, rdata}, {24'd0, mon_r.data});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) dm[i] = 8'(i) ^ 8'hA5;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = 0; dbg_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {30'd0, cpu_gnt, dbg_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_state", {30'd0, arb_state}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Unlocked contention alternates, CPU first; DM[11]=0xAE, DM[18]=0xB7.
    for (int k = 0; k < 3; k++) begin
      both_rd(1'b0, 8'd11, 8'd18, 2'b10, 8'hAE);
      both_rd(1'b0, 8'd11, 8'd18, 2'b01, 8'hB7);
    end

    // Write then read the same address on consecutive cycles.
    dbg_only(1'b1, 8'd11, 8'h5A, 8'h00);
    cpu_only(1'b0, 1'b0, 8'd11, 8'h00, 8'h5A);

    // CPU lock under contention: four CPU grants, DBG forced in, then CPU.
    dbg_only(1'b0, 8'd18, 8'h00, 8'hB7);
    for (int k = 0; k < 4; k++) both_rd(1'b1, 8'd3, 8'd4, 2'b10, 8'hA6);
    both_rd(1'b1, 8'd3, 8'd4, 2'b01, 8'hA1);
    both_rd(1'b1, 8'd3, 8'd4, 2'b10, 8'hA6);
    check("state_lock_cpu", {30'd0, arb_state}, 32'd1);

    // Lock owner drops req: DBG served, lock released, round robin resumes.
    dbg_only(1'b0, 8'd4, 8'h00, 8'hA1);
    check("state_released", {30'd0, arb_state}, 32'd0);
    both_rd(1'b0, 8'd11, 8'd18, 2'b10, 8'h5A);
    both_rd(1'b0, 8'd11, 8'd18, 2'b01, 8'hB7);

    // Reset lands between a read grant and its data edge.
    cpu_only(1'b0, 1'b0, 8'd18, 8'h00, 8'hB7);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = 8'd11; cpu_wdata = 8'h00;
    dbg_req = 1'b0;
    mon_g = '{gnt: 2'b10, we: 1'b0, addr: 8'd11, wdata: 8'h00};
    exp_gnt_q.push_back(mon_g);
    @(negedge clk); #1;
    reset = 1'b1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd18;
    #1;
    check("rst_mid_gnt", {30'd0, cpu_gnt, dbg_gnt}, 32'd0);
    check("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("rst_mid_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'd0);
      check("rst_mid_gnt_hold", {30'd0, cpu_gnt, dbg_gnt}, 32'd0);
    end
    reset = 1'b0;
    both_rd(1'b0, 8'd11, 8'd18, 2'b10, 8'h5A);
    both_rd(1'b0, 8'd11, 8'd18, 2'b01, 8'hB7);

    // Debug-only loader burst of writes to 0..9, then read some back.
    for (int i = 0; i < 10; i++) dbg_only(1'b1, 8'(i), 8'h30 + 8'(i), 8'h00);
    cpu_only(1'b0, 1'b0, 8'd9, 8'h00, 8'h39);
    dbg_only(1'b0, 8'd0, 8'h00, 8'h30);
    repeat (3) idle();

    check("gnt_queue_drained", exp_gnt_q.size(), 32'd0);
    check("rd_queue_drained", exp_rd_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
